// File: rtl/sccb_slave_regs.sv
// SCCB/I2C target with a 256 x 8 register file, oversampled on clk_50M.
// Register writes are reported on wr_strobe/wr_addr/wr_data and counted in write_count.
module sccb_slave_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h21,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk_50M,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic [15:0] write_count
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_SUB_ADDR, S_SUB_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [1:0] pin_w, lvl_w, prev_w;
  assign pin_w = {scl_in, sda_in};

  // Per line: 2-FF synchronizer, then a level that only moves after FILTER_LEN equal samples
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_cond
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          prev_q;

    always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= 2'b11;
        cnt_q  <= '0;
        lvl_q  <= 1'b1;
        prev_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[0], pin_w[gi]};
        prev_q <= lvl_q;
        if (sync_q[1] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
          lvl_q <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

    assign lvl_w[gi]  = lvl_q;
    assign prev_w[gi] = prev_q;
  end

  logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall, start_w, stop_w;
  assign scl_f    = lvl_w[1];
  assign sda_f    = lvl_w[0];
  assign scl_rise = scl_f & ~prev_w[1];
  assign scl_fall = ~scl_f & prev_w[1];
  assign sda_rise = sda_f & ~prev_w[0];
  assign sda_fall = ~sda_f & prev_w[0];
  assign start_w  = sda_fall & scl_f;
  assign stop_w   = sda_rise & scl_f;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, ptr_q;
  logic       rw_q, ack_drv_q, rd_load_q;
  logic [7:0] mem_q [256];
  logic [7:0] rx_byte_d, rd_byte_d;

  assign rx_byte_d = {shift_q[6:0], sda_f};
  assign rd_byte_d = mem_q[ptr_q];
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      ack_drv_q   <= 1'b0;
      rd_load_q   <= 1'b0;
      mem_q       <= '{default: 8'h00};
      sda_oe      <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      write_count <= 16'h0000;
    end else begin
      wr_strobe <= 1'b0;
      if (start_w) begin
        state_q   <= S_DEV_ADDR;
        bit_cnt_q <= 3'd0;
        sda_oe    <= 1'b0;
        ack_drv_q <= 1'b0;
        rd_load_q <= 1'b0;
      end else if (stop_w) begin
        state_q   <= S_IDLE;
        sda_oe    <= 1'b0;
        ack_drv_q <= 1'b0;
        rd_load_q <= 1'b0;
      end else begin
        case (state_q)
          S_DEV_ADDR, S_SUB_ADDR, S_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == S_DEV_ADDR) begin
                  if (rx_byte_d[7:1] == DEV_ADDR) begin
                    rw_q    <= rx_byte_d[0];
                    state_q <= S_DEV_ACK;
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_SUB_ADDR) begin
                  ptr_q   <= rx_byte_d;
                  state_q <= S_SUB_ACK;
                end else begin
                  mem_q[ptr_q] <= rx_byte_d;
                  wr_addr      <= ptr_q;
                  wr_data      <= rx_byte_d;
                  wr_strobe    <= 1'b1;
                  if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
                  state_q <= S_WR_ACK;
                end
              end
            end
          end
          // ACK slot: pull low on the falling edge after bit 8, release on the next one
          S_DEV_ACK, S_SUB_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                sda_oe    <= 1'b1;
                ack_drv_q <= 1'b1;
              end else begin
                ack_drv_q <= 1'b0;
                bit_cnt_q <= 3'd0;
                sda_oe    <= 1'b0;
                if (state_q == S_DEV_ACK && rw_q) begin
                  shift_q <= rd_byte_d;
                  sda_oe  <= ~rd_byte_d[7];
                  state_q <= S_RD_DATA;
                end else if (state_q == S_DEV_ACK) begin
                  state_q <= S_SUB_ADDR;
                end else begin
                  if (state_q == S_WR_ACK) ptr_q <= ptr_q + 8'd1;
                  state_q <= S_WR_DATA;
                end
              end
            end
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              if (rd_load_q) begin
                shift_q   <= rd_byte_d;
                sda_oe    <= ~rd_byte_d[7];
                bit_cnt_q <= 3'd0;
                rd_load_q <= 1'b0;
              end else if (bit_cnt_q == 3'd7) begin
                sda_oe    <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= S_RD_ACK;
              end else begin
                shift_q   <= {shift_q[6:0], 1'b0};
                sda_oe    <= ~shift_q[6];
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                ptr_q     <= ptr_q + 8'd1;
                rd_load_q <= 1'b1;
                state_q   <= S_RD_DATA;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_IGNORE: sda_oe <= 1'b0;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_slave_regs.sv
// Bit-banged SCCB master driving sccb_slave_regs over an open-drain SDA model.
// Table-driven writes/reads plus hand-written glitch and reset sequences.
module tb_sccb_slave_regs;

  logic        clk_50M = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, wr_strobe, busy;
  logic [7:0]  wr_addr, wr_data;
  logic [15:0] write_count;

  assign sda_bus = sda_m & ~sda_oe;

  sccb_slave_regs #(.DEV_ADDR(7'h21), .FILTER_LEN(3)) dut (
    .clk_50M     (clk_50M),
    .reset_n     (reset_n),
    .scl_in      (scl_m),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .write_count (write_count)
  );

  always #10 clk_50M = ~clk_50M;

  int   checks = 0;
  int   errors = 0;
  int   q_clks = 10;
  int   strobe_cnt = 0;
  bit   oe_any = 0, oe_after_en = 0, oe_after = 0, busy_seen = 0, glitch_on = 0;

  always @(negedge clk_50M) begin
    if (wr_strobe) strobe_cnt++;
    if (sda_oe) oe_any = 1'b1;
    if (oe_after_en && sda_oe) oe_after = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_start;
    sda_m = 1'b1; clks(q_clks);
    scl_m = 1'b1; clks(2 * q_clks);
    sda_m = 1'b0; clks(2 * q_clks);
    scl_m = 1'b0; clks(q_clks);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; clks(q_clks);
    scl_m = 1'b1; clks(2 * q_clks);
    sda_m = 1'b1; clks(2 * q_clks);
  endtask

  // One SCL period; an optional 2-clock SCL spike is inserted in the low phase
  task automatic clock_bit(input logic b, input bit spike, output logic s);
    sda_m = b;
    if (spike) begin
      clks(3); scl_m = 1'b1; clks(2); scl_m = 1'b0; clks(q_clks - 5);
    end else begin
      clks(q_clks);
    end
    scl_m = 1'b1; clks(q_clks);
    s = sda_bus;  clks(q_clks);
    scl_m = 1'b0; clks(q_clks);
  endtask

  task automatic send8(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], glitch_on && (i == 3), s);
      if (glitch_on && (i == 3)) glitch_on = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    send8(b);
    clock_bit(1'b1, 1'b0, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    oe_after_en = 1'b1;
    clock_bit(nack, 1'b0, s);
  endtask

  task automatic write_txn(input logic [7:0] dev, input logic [7:0] sub, input logic [7:0] dat,
                           output logic a0, output logic a1, output logic a2);
    bus_start;
    send_byte(dev, a0);
    send_byte(sub, a1);
    send_byte(dat, a2);
    bus_stop;
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] d,
                          output logic a0, output logic a1, output logic a2);
    bus_start;
    send_byte(8'h42, a0);
    send_byte(addr, a1);
    bus_stop;
    bus_start;
    send_byte(8'h43, a2);
    oe_after = 1'b0;
    recv_byte(1'b1, d);
    bus_stop;
    oe_after_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] sub;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_data;
  } rd_vec_t;

  wr_vec_t     wr_tab [4];
  rd_vec_t     rd_tab [7];
  logic        a0, a1, a2, a3;
  logic [7:0]  rd;
  logic [7:0]  last_addr, last_data;
  logic [15:0] exp_count;
  int          s0, n;

  initial begin
    wr_tab[0] = '{8'h42, 8'h0A, 8'h76, 1'b1};
    wr_tab[1] = '{8'h42, 8'h33, 8'hC3, 1'b1};
    wr_tab[2] = '{8'h42, 8'h7F, 8'h01, 1'b1};
    wr_tab[3] = '{8'h44, 8'h50, 8'h99, 1'b0};
    rd_tab[0] = '{8'h12, 8'h80};
    rd_tab[1] = '{8'h0A, 8'h76};
    rd_tab[2] = '{8'hFF, 8'h11};
    rd_tab[3] = '{8'h00, 8'h22};
    rd_tab[4] = '{8'h33, 8'hC3};
    rd_tab[5] = '{8'h7F, 8'h01};
    rd_tab[6] = '{8'h50, 8'h00};
    exp_count = 16'd0;
    last_addr = 8'h00;
    last_data = 8'h00;

    clks(5);
    reset_n = 1'b1;
    clks(20);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_write_count", write_count, 0);

    // 100 kHz SCL: 500 system clocks per bit
    q_clks = 125;
    s0 = strobe_cnt;
    write_txn(8'h42, 8'h12, 8'h80, a0, a1, a2);
    exp_count++; last_addr = 8'h12; last_data = 8'h80;
    $display("write100k dev=42 sub=12 data=80 acks=%b%b%b count=%0d", a0, a1, a2, write_count);
    chk("w100k_ack_dev", a0, 1);
    chk("w100k_ack_sub", a1, 1);
    chk("w100k_ack_data", a2, 1);
    chk("w100k_strobes", strobe_cnt - s0, 1);
    chk("w100k_wr_addr", wr_addr, 8'h12);
    chk("w100k_wr_data", wr_data, 8'h80);
    chk("w100k_count", write_count, exp_count);
    chk("w100k_busy_after_stop", busy, 0);
    q_clks = 10;

    for (int i = 0; i < 4; i++) begin
      s0 = strobe_cnt;
      write_txn(wr_tab[i].dev, wr_tab[i].sub, wr_tab[i].data, a0, a1, a2);
      if (wr_tab[i].exp_ack) begin
        exp_count++; last_addr = wr_tab[i].sub; last_data = wr_tab[i].data;
      end
      $display("write dev=%h sub=%h data=%h acks=%b%b%b count=%0d",
               wr_tab[i].dev, wr_tab[i].sub, wr_tab[i].data, a0, a1, a2, write_count);
      chk($sformatf("wtab%0d_ack_dev", i), a0, wr_tab[i].exp_ack);
      chk($sformatf("wtab%0d_ack_sub", i), a1, wr_tab[i].exp_ack);
      chk($sformatf("wtab%0d_ack_data", i), a2, wr_tab[i].exp_ack);
      chk($sformatf("wtab%0d_strobes", i), strobe_cnt - s0, wr_tab[i].exp_ack ? 1 : 0);
      chk($sformatf("wtab%0d_wr_addr", i), wr_addr, last_addr);
      chk($sformatf("wtab%0d_wr_data", i), wr_data, last_data);
      chk($sformatf("wtab%0d_count", i), write_count, exp_count);
      chk($sformatf("wtab%0d_busy", i), busy, 0);
    end

    // Pointer set by a sub-address-only write, then a 1-byte read with NACK
    s0 = strobe_cnt;
    read_reg(8'h0A, rd, a0, a1, a2);
    $display("read 0x0A data=%h acks=%b%b%b oe_after=%0d", rd, a0, a1, a2, oe_after);
    chk("rd0A_ack_wr_dev", a0, 1);
    chk("rd0A_ack_sub", a1, 1);
    chk("rd0A_ack_rd_dev", a2, 1);
    chk("rd0A_data", rd, 8'h76);
    chk("rd0A_oe_after_data", oe_after, 0);
    chk("rd0A_no_strobe", strobe_cnt - s0, 0);
    chk("rd0A_count_kept", write_count, exp_count);
    chk("rd0A_busy", busy, 0);

    s0 = strobe_cnt;
    oe_any = 1'b0;
    write_txn(8'h60, 8'h12, 8'h55, a0, a1, a2);
    $display("mismatch dev=60 sub=12 data=55 acks=%b%b%b oe_seen=%0d", a0, a1, a2, oe_any);
    chk("mis_oe_never", oe_any, 0);
    chk("mis_no_ack", {a0, a1, a2}, 3'b000);
    chk("mis_no_strobe", strobe_cnt - s0, 0);
    chk("mis_count", write_count, exp_count);

    s0 = strobe_cnt;
    bus_start;
    send_byte(8'h42, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop;
    exp_count += 16'd2; last_addr = 8'h00; last_data = 8'h22;
    $display("burst sub=FF data=11,22 acks=%b%b%b%b count=%0d", a0, a1, a2, a3, write_count);
    chk("burst_acks", {a0, a1, a2, a3}, 4'b1111);
    chk("burst_strobes", strobe_cnt - s0, 2);
    chk("burst_count", write_count, exp_count);
    chk("burst_wr_addr", wr_addr, 8'h00);
    chk("burst_wr_data", wr_data, 8'h22);

    for (int i = 0; i < 7; i++) begin
      read_reg(rd_tab[i].addr, rd, a0, a1, a2);
      $display("read addr=%h data=%h acks=%b%b%b", rd_tab[i].addr, rd, a0, a1, a2);
      chk($sformatf("rtab%0d_acks", i), {a0, a1, a2}, 3'b111);
      chk($sformatf("rtab%0d_data", i), rd, rd_tab[i].exp_data);
      chk($sformatf("rtab%0d_oe_after", i), oe_after, 0);
    end
    chk("rtab_count_kept", write_count, exp_count);

    // 2-clock SDA dip on an idle bus must not register as START
    clks(10);
    busy_seen = 1'b0;
    sda_m = 1'b0; clks(2); sda_m = 1'b1;
    clks(30);
    $display("sda glitch idle busy_seen=%0d", busy_seen);
    chk("glitch_sda_no_start", busy_seen, 0);

    s0 = strobe_cnt;
    bus_start;
    send_byte(8'h42, a0);
    send_byte(8'h44, a1);
    glitch_on = 1'b1;
    send_byte(8'h5C, a2);
    bus_stop;
    exp_count++; last_addr = 8'h44; last_data = 8'h5C;
    $display("scl glitch write sub=44 data=%h acks=%b%b%b", wr_data, a0, a1, a2);
    chk("glitch_scl_acks", {a0, a1, a2}, 3'b111);
    chk("glitch_scl_strobes", strobe_cnt - s0, 1);
    chk("glitch_scl_wr_addr", wr_addr, 8'h44);
    chk("glitch_scl_wr_data", wr_data, 8'h5C);
    chk("glitch_scl_count", write_count, exp_count);

    // Reset asserted while the device-address ACK is being driven
    bus_start;
    send8(8'h42);
    n = 0;
    while (!sda_oe && n < 50) begin
      clks(1);
      n++;
    end
    chk("rstmid_ack_driven", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    $display("reset mid-ack sda_oe=%b busy=%b count=%0d", sda_oe, busy, write_count);
    chk("rstmid_sda_oe_async", sda_oe, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_count", write_count, 0);
    chk("rstmid_wr_addr", wr_addr, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    clks(10);
    reset_n = 1'b1;
    clks(20);
    exp_count = 16'd0;

    s0 = strobe_cnt;
    write_txn(8'h42, 8'h01, 8'h5A, a0, a1, a2);
    exp_count++;
    $display("post-reset write sub=01 data=5A acks=%b%b%b count=%0d", a0, a1, a2, write_count);
    chk("post_acks", {a0, a1, a2}, 3'b111);
    chk("post_strobes", strobe_cnt - s0, 1);
    chk("post_wr_addr", wr_addr, 8'h01);
    chk("post_wr_data", wr_data, 8'h5A);
    chk("post_count", write_count, exp_count);

    read_reg(8'h0A, rd, a0, a1, a2);
    $display("post-reset read addr=0A data=%h", rd);
    chk("post_reg0A_cleared", rd, 8'h00);
    read_reg(8'h01, rd, a0, a1, a2);
    $display("post-reset read addr=01 data=%h", rd);
    chk("post_reg01", rd, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_slave_regs.md
Name: sccb_slave_regs

Overview:
- SCCB/I2C responder with a 256 x 8 register file; the target side of the camera configuration link.
- Used as a sensor-register model in loopback and bench setups, so the camera configuration master can be exercised without a real sensor.
- Oversamples SCL and SDA on the system clock.
- Acknowledges write and read transfers and reports every register write on a strobe interface.

Parameters:
- DEV_ADDR, 7'h21, 7-bit device address (write byte 0x42, read byte 0x43).
- FILTER_LEN, 3, consecutive equal samples required before a filtered SCL/SDA level changes.

Ports:
- clk_50M  input  1  system clock; all logic is on this clock.
- reset_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  SCL pin level; asynchronous to clk_50M.
- sda_in  input  1  SDA pin level; asynchronous to clk_50M.
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
- wr_strobe  output  1  one-cycle pulse when a register write completes.
- wr_addr  output  8  sub-address of the last write; held between writes.
- wr_data  output  8  data of the last write; held between writes.
- busy  output  1  1 whenever the state is not IDLE.
- write_count  output  16  number of completed register writes; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, reset_n low):
  - sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, write_count=0.
  - All 256 registers = 0x00; sub-address pointer = 0; state = IDLE.
- Input conditioning:
  - scl_in and sda_in each pass a 2-FF synchronizer, then a FILTER_LEN-sample glitch filter.
  - A filtered level changes only after FILTER_LEN consecutive equal synchronized samples.
  - Edge pulses are derived from the filtered levels, so pin-to-edge latency is FILTER_LEN+2 clocks.
- Bus conditions:
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
  - START/STOP take priority over bit handling in the same cycle.
  - START (including repeated START) in any state -> DEV_ADDR with bit counter cleared and sda_oe=0.
  - STOP in any state -> IDLE with sda_oe=0.
- Bit rules:
  - Received bits are sampled on the SCL rising edge, MSB first, with a 3-bit bit counter.
  - Slave-driven bits change on the SCL falling edge.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift in 8 bits. Byte[7:1]==DEV_ADDR -> DEV_ACK, with rw=byte[0]. Mismatch -> IGNORE; the slave never drives SDA.
  - DEV_ACK: on the SCL falling edge after bit 8, sda_oe=1; release on the next falling edge. Then rw=0 -> SUB_ADDR; rw=1 -> RD_DATA.
  - SUB_ADDR: shift in 8 bits and load the pointer -> SUB_ACK, which ACKs as in DEV_ACK -> WR_DATA.
  - WR_DATA: on the 8th rising edge:
    - reg[ptr] <= byte; wr_addr <= ptr; wr_data <= byte;
    - wr_strobe pulses for 1 clock; write_count increments (saturating);
    - go to WR_ACK.
  - WR_ACK: ACK; pointer increments mod 256 (0xFF wraps to 0x00) -> WR_DATA, so bursts are supported.
  - RD_DATA:
    - On the ACK-release falling edge, load reg[ptr] into the shift register.
    - Drive sda_oe = ~bit on each falling edge; 8 bits are sent.
    - After the 8th bit's falling edge, sda_oe=0 -> RD_ACK.
  - RD_ACK: sample the master bit on the 9th rising edge.
    - Low (ACK): pointer increments mod 256, then back to RD_DATA.
    - High (NACK): go to IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- A read without a preceding write uses the current pointer, which is the value left by the last transaction.
- STOP in mid-byte discards the partial byte: no write and no strobe.
- A read does not change write_count or wr_strobe.

Test Plan:
- Write txn 0x42, 0x12, 0x80, STOP at 100 kHz SCL:
  - slave ACKs the three 9th clocks;
  - wr_strobe pulses once with wr_addr=0x12, wr_data=0x80;
  - write_count=1; busy=0 after STOP.
- Write 0x0A=0x76, then 0x42, 0x0A, STOP, then START 0x43, read 1 byte, master NACK, STOP:
  - SDA carries 0x76 MSB first;
  - sda_oe=0 after the 8th data bit and stays 0 through STOP.
- Address mismatch 0x60, 0x12, 0x55:
  - sda_oe stays 0 for the whole transaction; no wr_strobe; register 0x12 unchanged.
- Burst 0x42, 0xFF, 0x11, 0x22, STOP:
  - reg[0xFF]=0x11, reg[0x00]=0x22 (wrap);
  - two wr_strobe pulses; write_count +2.
- Glitch immunity:
  - 2-clock SDA low pulse while SCL is high (FILTER_LEN=3) -> no START, busy stays 0.
  - 2-clock SCL spike during a data bit -> no extra bit shifted, byte intact.
- Reset mid-operation: drop reset_n while sda_oe=1 during DEV_ACK:
  - sda_oe=0 immediately (asynchronously); state IDLE; all registers 0x00; write_count=0;
  - after release, the next 0x42, 0x01, 0x5A write completes normally.
